cpu_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute controller for the 8-bit W-accumulator CPU datapath.
- Owns the program counter and the hardware return stack.
- Requests instruction words from program memory over a req/ack handshake that tolerates wait states, latches the instruction register and decodes the literal/control opcode subset.
- Drives the ALU op select and the W load enable; the ALU and W register stay in the datapath.

---
 rtl/cpu_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the 8-bit W-accumulator CPU.
// Owns the program counter, the circular return stack and the instruction-fetch handshake.
module cpu_sequencer #(
  parameter int              PC_W         = 11,
  parameter int              IR_W         = 14,
  parameter int              STACK_DEPTH  = 8,
  parameter logic [PC_W-1:0] RESET_VECTOR = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            wake,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IR_W-1:0] imem_data,
  output logic [IR_W-1:0] ir_out,
  output logic [PC_W-1:0] pc_out,
  output logic [2:0]      alu_op,
  output logic            load_w,
  output logic            halted,
  output logic            illegal,
  output logic            stack_ovf,
  output logic            stack_unf
);
  localparam int SP_W  = $clog2(STACK_DEPTH);
  localparam int CNT_W = SP_W + 1;
  localparam logic [PC_W-1:0]  PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [SP_W-1:0]  SP_ONE    = {{(SP_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(STACK_DEPTH);
  localparam logic [2:0]       OP_IDLE   = 3'd7;
  localparam logic [IR_W-1:0]  IR_NOP    = {IR_W{1'b0}};
  localparam logic [IR_W-1:0]  IR_RETURN = {{(IR_W-8){1'b0}}, 8'h08};
  localparam logic [IR_W-1:0]  IR_SLEEP  = {{(IR_W-8){1'b0}}, 8'h63};

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;
  typedef enum logic [2:0] {C_NOP, C_ALU, C_RETLW, C_GOTO, C_CALL, C_RETURN, C_SLEEP, C_ILLEGAL} cls_t;
  typedef struct packed {
    cls_t       cls;
    logic [2:0] op;
  } dec_t;

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [IR_W-1:0]  ir_q, ir_d;
  logic [SP_W-1:0]  sp_q, sp_d, sp_dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  stack_q [STACK_DEPTH];
  logic [PC_W-1:0]  stack_d [STACK_DEPTH];
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             imem_req_q, imem_req_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             load_w_q, load_w_d;
  logic             illegal_q, illegal_d;
  logic             halted_q, halted_d;
  dec_t             dec;

  function automatic dec_t decode(input logic [IR_W-1:0] ir);
    dec_t d;
    d.cls = C_ILLEGAL;
    d.op  = OP_IDLE;
    casez (ir[IR_W-1 -: 6])
      6'b1100??: begin d.cls = C_ALU;   d.op = 3'd5; end
      6'b1101??: begin d.cls = C_RETLW; d.op = 3'd5; end
      6'b111000: begin d.cls = C_ALU;   d.op = 3'd3; end
      6'b111001: begin d.cls = C_ALU;   d.op = 3'd2; end
      6'b111010: begin d.cls = C_ALU;   d.op = 3'd4; end
      6'b11110?: begin d.cls = C_ALU;   d.op = 3'd1; end
      6'b11111?: begin d.cls = C_ALU;   d.op = 3'd0; end
      6'b101???: d.cls = C_GOTO;
      6'b100???: d.cls = C_CALL;
      default: begin
        if (ir == IR_NOP)         d.cls = C_NOP;
        else if (ir == IR_RETURN) d.cls = C_RETURN;
        else if (ir == IR_SLEEP)  d.cls = C_SLEEP;
        else                      d.cls = C_ILLEGAL;
      end
    endcase
    return d;
  endfunction

  // Next-state, datapath-control and return-stack logic; control outputs are
  // computed one state early so that the registered versions line up with EXEC.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    cls_d      = cls_q;
    sp_d       = sp_q;
    cnt_d      = cnt_q;
    stack_d    = stack_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    imem_req_d = 1'b0;
    alu_op_d   = OP_IDLE;
    load_w_d   = 1'b0;
    illegal_d  = 1'b0;
    halted_d   = 1'b0;
    dec        = decode(ir_q);
    sp_dec     = sp_q - SP_ONE;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d    = S_FETCH;
          imem_req_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + PC_ONE;
          state_d = S_DECODE;
        end else begin
          imem_req_d = 1'b1;
        end
      end
      S_DECODE: begin
        cls_d   = dec.cls;
        state_d = S_EXEC;
        if (dec.cls == C_ALU || dec.cls == C_RETLW) begin
          alu_op_d = dec.op;
          load_w_d = 1'b1;
        end else if (dec.cls == C_ILLEGAL) begin
          illegal_d = 1'b1;
        end else begin
          alu_op_d = OP_IDLE;
        end
      end
      S_EXEC: begin
        // pc already points past this instruction, so CALL pushes it unchanged
        case (cls_q)
          C_GOTO: pc_d = ir_q[PC_W-1:0];
          C_CALL: begin
            stack_d[sp_q] = pc_q;
            sp_d          = sp_q + SP_ONE;
            pc_d          = ir_q[PC_W-1:0];
            if (cnt_q == CNT_FULL) ovf_d = 1'b1;
            else                   cnt_d = cnt_q + CNT_ONE;
          end
          C_RETLW, C_RETURN: begin
            sp_d = sp_dec;
            pc_d = stack_q[sp_dec];
            if (cnt_q == {CNT_W{1'b0}}) unf_d = 1'b1;
            else                        cnt_d = cnt_q - CNT_ONE;
          end
          default: pc_d = pc_q;
        endcase
        if (cls_q == C_SLEEP) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (run) begin
          state_d    = S_FETCH;
          imem_req_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT: begin
        if (wake) begin
          state_d    = S_FETCH;
          imem_req_d = 1'b1;
        end else begin
          halted_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cls_q      <= C_NOP;
      pc_q       <= RESET_VECTOR;
      ir_q       <= {IR_W{1'b0}};
      sp_q       <= {SP_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      imem_req_q <= 1'b0;
      alu_op_q   <= OP_IDLE;
      load_w_q   <= 1'b0;
      illegal_q  <= 1'b0;
      halted_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= {PC_W{1'b0}};
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      sp_q       <= sp_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      imem_req_q <= imem_req_d;
      alu_op_q   <= alu_op_d;
      load_w_q   <= load_w_d;
      illegal_q  <= illegal_d;
      halted_q   <= halted_d;
      stack_q    <= stack_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign ir_out    = ir_q;
  assign pc_out    = pc_q;
  assign alu_op    = alu_op_q;
  assign load_w    = load_w_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: ROM model with wait states, scoreboard of
// expected EXEC outputs, table-driven decode vectors and hand-written corner sequences.
module tb_cpu_sequencer;
  logic        clk = 1'b0;
  logic        reset, run, wake, imem_req, imem_ack;
  logic        load_w, halted, illegal, stack_ovf, stack_unf;
  logic [10:0] imem_addr, pc_out;
  logic [13:0] imem_data, ir_out;
  logic [2:0]  alu_op;

  cpu_sequencer #(.PC_W(11), .IR_W(14), .STACK_DEPTH(8), .RESET_VECTOR(11'd0)) dut (
    .clk(clk), .reset(reset), .run(run), .wake(wake),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .ir_out(ir_out), .pc_out(pc_out), .alu_op(alu_op), .load_w(load_w), .halted(halted),
    .illegal(illegal), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  typedef struct { logic [13:0] word; logic [2:0] op; logic ld; logic ill; } vec_t;
  typedef struct { logic [2:0] op; logic ld; logic ill; } exp_t;

  logic [13:0] rom     [0:2047];
  exp_t        exp_mem [0:2047];
  exp_t        sb_q[$];
  int          ld_cyc[$];
  int          fetch_log[$];
  logic [1:0]  flag_log[$];
  int          n_chk = 0, n_pass = 0, cyc = 0;
  int          fires = 0, max_fires = 0, stop_after = 0, lat = 0, wcnt = 0;
  bit          manual = 1'b0, pend1 = 1'b0, pend2 = 1'b0, prev_req = 1'b0;
  logic [10:0] prev_addr = 11'd0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) begin
      rom[i]     = 14'h0000;
      exp_mem[i] = '{3'd7, 1'b0, 1'b0};
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1; run = 1'b0; wake = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete(); ld_cyc.delete(); fetch_log.delete(); flag_log.delete();
    fires = 0; wcnt = 0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!(fires == stop_after && sb_q.size() == 0) && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk("run_complete", {31'd0, (fires == stop_after && sb_q.size() == 0)}, 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("parked_no_req", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic run_prog(input int nfires, input int latency, input int budget);
    ld_cyc.delete(); fetch_log.delete(); flag_log.delete();
    lat = latency; fires = 0; wcnt = 0; max_fires = nfires; stop_after = nfires;
    run = 1'b1;
    wait_done(budget);
  endtask

  // ROM responder, fetch logger and scoreboard checker; EXEC is two cycles after the ack edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (pend2) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_underrun: EXEC with no expected entry (t=%0t)", $time);
      end else begin
        e = sb_q.pop_front();
        chk("exec_outputs", {27'd0, alu_op, load_w, illegal}, {27'd0, e.op, e.ld, e.ill});
      end
    end else begin
      chk("quiet_outputs", {27'd0, alu_op, load_w, illegal}, {27'd0, 3'd7, 1'b0, 1'b0});
    end
    if (load_w === 1'b1) ld_cyc.push_back(cyc);
    pend2 = pend1;
    pend1 = 1'b0;
    if (!manual) begin
      if (imem_req === 1'b1 && reset === 1'b0) begin
        if (prev_req) chk("addr_stable", {21'd0, imem_addr}, {21'd0, prev_addr});
        if (fires < max_fires && wcnt >= lat) begin
          imem_ack  = 1'b1;
          imem_data = rom[imem_addr];
          sb_q.push_back(exp_mem[imem_addr]);
          fetch_log.push_back(int'(imem_addr));
          flag_log.push_back({stack_ovf, stack_unf});
          fires++;
          wcnt  = 0;
          pend1 = 1'b1;
          if (fires == stop_after) run = 1'b0;
        end else begin
          imem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wcnt     = 0;
      end
    end
    prev_req  = (imem_req === 1'b1);
    prev_addr = imem_addr;
  end

  initial begin
    vec_t tbl [14];
    int   exp_fetch [18];
    reset = 1'b1; run = 1'b0; wake = 1'b0; imem_ack = 1'b0; imem_data = 14'h0000;
    clear_rom();
    tbl = '{'{14'h3044, 3'd5, 1'b1, 1'b0}, '{14'h3E01, 3'd0, 1'b1, 1'b0},
            '{14'h3802, 3'd3, 1'b1, 1'b0}, '{14'h39FE, 3'd2, 1'b1, 1'b0},
            '{14'h3C47, 3'd1, 1'b1, 1'b0}, '{14'h3A55, 3'd4, 1'b1, 1'b0},
            '{14'h3AAA, 3'd4, 1'b1, 1'b0}, '{14'h33FF, 3'd5, 1'b1, 1'b0},
            '{14'h3F00, 3'd0, 1'b1, 1'b0}, '{14'h3D80, 3'd1, 1'b1, 1'b0},
            '{14'h0000, 3'd7, 1'b0, 1'b0}, '{14'h0100, 3'd7, 1'b0, 1'b1},
            '{14'h3B00, 3'd7, 1'b0, 1'b1}, '{14'h1FFF, 3'd7, 1'b0, 1'b1}};

    // reset state
    do_reset();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", {21'd0, pc_out}, 32'd0);
    chk("rst_ir", {18'd0, ir_out}, 32'd0);
    chk("rst_flags", {27'd0, load_w, halted, illegal, stack_ovf, stack_unf}, 32'd0);
    chk("rst_alu_op", {29'd0, alu_op}, 32'd7);

    // table-driven program, zero wait: 3 cycles per instruction
    for (int i = 0; i < 14; i++) begin
      rom[i]     = tbl[i].word;
      exp_mem[i] = '{tbl[i].op, tbl[i].ld, tbl[i].ill};
    end
    run_prog(7, 0, 100);
    chk("prog0_pc", {21'd0, pc_out}, 32'd7);
    chk("prog0_ir", {18'd0, ir_out}, 32'h3AAA);
    chk("prog0_ld_count", ld_cyc.size(), 32'd7);
    for (int i = 1; i < ld_cyc.size(); i++) chk("prog0_period", ld_cyc[i] - ld_cyc[i-1], 32'd3);

    // same program, three wait states per fetch: 6 cycles per instruction
    do_reset();
    run_prog(7, 3, 200);
    chk("prog3_pc", {21'd0, pc_out}, 32'd7);
    chk("prog3_ld_count", ld_cyc.size(), 32'd7);
    for (int i = 1; i < ld_cyc.size(); i++) chk("prog3_period", ld_cyc[i] - ld_cyc[i-1], 32'd6);

    // resume from IDLE through the rest of the table, one wait state
    run_prog(7, 1, 200);
    chk("prog_rest_pc", {21'd0, pc_out}, 32'd14);
    for (int i = 0; i < fetch_log.size(); i++) chk("prog_rest_addr", fetch_log[i], 7 + i);

    // CALL 5 then RETLW 0x11
    do_reset(); clear_rom();
    rom[0] = 14'h2005; rom[5] = 14'h3411; exp_mem[5] = '{3'd5, 1'b1, 1'b0};
    run_prog(3, 0, 100);
    chk("call_fetch_count", fetch_log.size(), 32'd3);
    if (fetch_log.size() == 3) begin
      chk("call_fetch0", fetch_log[0], 32'd0);
      chk("call_fetch1", fetch_log[1], 32'd5);
      chk("call_fetch2", fetch_log[2], 32'd1);
    end
    chk("call_flags", {30'd0, stack_ovf, stack_unf}, 32'd0);
    chk("call_pc", {21'd0, pc_out}, 32'd2);

    // nine nested CALLs then nine RETURNs on an 8-deep stack
    do_reset(); clear_rom();
    for (int i = 0; i < 9; i++) rom[i*16] = 14'h2000 | 14'((i + 1) * 16);
    rom[144] = 14'h0008;
    for (int i = 1; i < 9; i++) rom[i*16 + 1] = 14'h0008;
    for (int i = 0; i < 9; i++) exp_fetch[i] = i * 16;
    exp_fetch[9] = 144;
    for (int j = 0; j < 8; j++) exp_fetch[10 + j] = (8 - j) * 16 + 1;
    run_prog(18, 0, 400);
    chk("nest_fetch_count", fetch_log.size(), 32'd18);
    if (fetch_log.size() == 18) begin
      for (int i = 0; i < 18; i++) chk("nest_fetch_addr", fetch_log[i], exp_fetch[i]);
      chk("ovf_after_8_calls", {31'd0, flag_log[8][1]}, 32'd0);
      chk("ovf_after_9_calls", {31'd0, flag_log[9][1]}, 32'd1);
      chk("unf_after_8_pops", {31'd0, flag_log[17][0]}, 32'd0);
    end
    chk("unf_after_9_pops", {31'd0, stack_unf}, 32'd1);
    chk("ovf_sticky", {31'd0, stack_ovf}, 32'd1);
    chk("nest_final_pc", {21'd0, pc_out}, 32'h81);

    // SLEEP at address 3, wake resumes at 4
    do_reset(); clear_rom();
    rom[3] = 14'h0063; rom[4] = 14'h3012; exp_mem[4] = '{3'd5, 1'b1, 1'b0};
    lat = 0; fires = 0; wcnt = 0; max_fires = 5; stop_after = 5;
    run = 1'b1;
    for (int k = 0; k < 60 && halted !== 1'b1; k++) begin
      @(negedge clk); #1;
    end
    chk("halt_entered", {31'd0, halted}, 32'd1);
    chk("halt_pc", {21'd0, pc_out}, 32'd4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("halt_hold", {30'd0, halted, imem_req}, 32'd2);
    end
    wake = 1'b1;
    @(negedge clk); #1;
    wake = 1'b0;
    chk("wake_req", {31'd0, imem_req}, 32'd1);
    chk("wake_addr", {21'd0, imem_addr}, 32'd4);
    chk("wake_halted", {31'd0, halted}, 32'd0);
    wait_done(60);
    chk("wake_pc", {21'd0, pc_out}, 32'd5);
    chk("wake_ld_count", ld_cyc.size(), 32'd1);

    // reset during a pending fetch, with ack in the same cycle and a late ack afterwards
    do_reset(); clear_rom();
    rom[0] = 14'h2955;
    lat = 0; fires = 0; wcnt = 0; max_fires = 1; stop_after = 99;
    run = 1'b1;
    for (int k = 0; k < 40 && !(imem_req === 1'b1 && imem_addr == 11'h155); k++) begin
      @(negedge clk); #1;
    end
    chk("pending_fetch", {20'd0, imem_req, imem_addr}, {20'd0, 1'b1, 11'h155});
    repeat (2) @(negedge clk);
    #1;
    manual = 1'b1;
    chk("ir_before_reset", {18'd0, ir_out}, 32'h2955);
    @(negedge clk); #1;
    reset = 1'b1; imem_ack = 1'b1; imem_data = 14'h3FFF;
    @(negedge clk); #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_pc", {21'd0, pc_out}, 32'd0);
    chk("midrst_ir", {18'd0, ir_out}, 32'd0);
    chk("midrst_flags", {27'd0, load_w, halted, illegal, stack_ovf, stack_unf}, 32'd0);
    chk("midrst_alu_op", {29'd0, alu_op}, 32'd7);
    reset = 1'b0; run = 1'b0;
    @(negedge clk); #1;
    chk("late_ack_ir", {18'd0, ir_out}, 32'd0);
    chk("late_ack_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b0;
    manual = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard stop in case the sequencer wedges somewhere the bounded waits do not cover.
  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule
